oai222_x4: RTL and testbench

Three-group OR-AND-INVERT cell (OAI222, drive strength X4) for the standard-cell logic library. It computes ZN = NOT((A1 OR A2) AND (B1 OR B2) AND (C1 OR C2)) combinationally. A clocked observation wrapper sits on the same module and supplies a registered copy of ZN, per-group status and a transition counter for in-system characterisation. The cell drops into datapath and control logic wherever a 6-input OAI function is needed.

---
 rtl/oai222_x4.sv | 59 +++++
 tb/tb_oai222_x4.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/oai222_x4.sv
// oai222_x4 -- OAI222 standard cell (drive X4) with a clocked observation wrapper.
//
// ZN = ~((A1|A2) & (B1|B2) & (C1|C2)) is purely combinational. It does not
// depend on clk or rst, so it stays valid when those pins are left unconnected.
//
// Ports:
//   A1..C2    in   1   three input pairs (groups A, B, C)
//   ZN        out  1   combinational OAI222 result
//   clk       in   1   rising-edge clock, used by the observation registers only
//   rst       in   1   asynchronous active-high reset of the observation registers
//   zn_q      out  1   ZN sampled at the previous rising clk edge (resets to 1)
//   grp_or    out  3   combinational group ORs {A, B, C} (bit2 = A)
//   seen_low  out  1   sticky: ZN was sampled 0 since reset
//   seen_high out  1   sticky: ZN was sampled 1 since reset
//   tog_cnt   out 16   saturating count of sampled ZN transitions
module oai222_x4 (
  input  logic        A1,
  input  logic        A2,
  input  logic        B1,
  input  logic        B2,
  input  logic        C1,
  input  logic        C2,
  output logic        ZN,
  input  logic        clk,
  input  logic        rst,
  output logic        zn_q,
  output logic [2:0]  grp_or,
  output logic        seen_low,
  output logic        seen_high,
  output logic [15:0] tog_cnt
);

  logic primed;

  always_comb begin
    grp_or = {A1 | A2, B1 | B2, C1 | C2};
    ZN     = ~((A1 | A2) & (B1 | B2) & (C1 | C2));
  end

  // The first edge after reset only primes zn_q. Comparing against the reset
  // value of zn_q on that edge would not be a real transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zn_q      <= 1'b1;
      seen_low  <= 1'b0;
      seen_high <= 1'b0;
      tog_cnt   <= '0;
      primed    <= 1'b0;
    end else begin
      zn_q      <= ZN;
      primed    <= 1'b1;
      if (!ZN) seen_low  <= 1'b1;
      if (ZN)  seen_high <= 1'b1;
      if (primed && (ZN != zn_q) && (tog_cnt != '1))
        tog_cnt <= tog_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_oai222_x4.sv
module tb_oai222_x4;

  logic        A1, A2, B1, B2, C1, C2;
  logic        clk, rst;
  logic        ZN, zn_q, seen_low, seen_high;
  logic [2:0]  grp_or;
  logic [15:0] tog_cnt;

  oai222_x4 dut (
    .A1(A1), .A2(A2), .B1(B1), .B2(B2), .C1(C1), .C2(C2),
    .ZN(ZN), .clk(clk), .rst(rst),
    .zn_q(zn_q), .grp_or(grp_or),
    .seen_low(seen_low), .seen_high(seen_high), .tog_cnt(tog_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  bit          chk_en  = 1'b0;

  // Reference model state.
  logic        m_zq     = 1'b1;
  logic        m_low    = 1'b0;
  logic        m_high   = 1'b0;
  int unsigned m_cnt    = 0;
  bit          m_primed = 1'b0;

  function automatic logic exp_zn(input logic [5:0] v);
    // ZN is low only when every pair holds at least one 1.
    return !((v[5:4] != 2'b00) && (v[3:2] != 2'b00) && (v[1:0] != 2'b00));
  endfunction

  function automatic logic [2:0] exp_grp(input logic [5:0] v);
    return {v[5:4] != 2'b00, v[3:2] != 2'b00, v[1:0] != 2'b00};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic set_in(input logic [5:0] v);
    {A1, A2, B1, B2, C1, C2} = v;
  endtask

  function automatic logic [5:0] cur_in();
    return {A1, A2, B1, B2, C1, C2};
  endfunction

  task automatic model_reset();
    m_zq = 1'b1; m_low = 1'b0; m_high = 1'b0; m_cnt = 0; m_primed = 1'b0;
  endtask

  task automatic model_edge(input logic [5:0] v);
    logic s;
    s = exp_zn(v);
    if (m_primed && (s != m_zq) && (m_cnt < 65535)) m_cnt++;
    m_zq = s;
    if (s) m_high = 1'b1; else m_low = 1'b1;
    m_primed = 1'b1;
  endtask

  // Called at posedge+1: drive, check the combinational outputs, cross one edge.
  task automatic apply(input logic [5:0] v);
    set_in(v);
    #1;
    check("ZN", {15'd0, ZN}, {15'd0, exp_zn(v)});
    check("grp_or", {13'd0, grp_or}, {13'd0, exp_grp(v)});
    @(posedge clk);
    #1;
    if (!rst) model_edge(v);
  endtask

  task automatic check_reset_regs(input string tag);
    check({tag, "_zn_q"},      {15'd0, zn_q},      16'd1);
    check({tag, "_seen_low"},  {15'd0, seen_low},  16'd0);
    check({tag, "_seen_high"}, {15'd0, seen_high}, 16'd0);
    check({tag, "_tog_cnt"},   tog_cnt,            16'd0);
  endtask

  // Per-cycle comparison of the registered outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_zn_q",      {15'd0, zn_q},      {15'd0, m_zq});
      check("cyc_seen_low",  {15'd0, seen_low},  {15'd0, m_low});
      check("cyc_seen_high", {15'd0, seen_high}, {15'd0, m_high});
      check("cyc_tog_cnt",   tog_cnt,            16'(m_cnt));
    end
  end

  initial begin
    int unsigned zeros;
    logic [5:0]  v;
    rst = 1'b1;
    set_in(6'b000000);
    #1;
    check_reset_regs("rst0");
    chk_en = 1'b1;

    // Exhaustive sweep (registers held in reset).
    zeros = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      v = 6'(i);
      set_in(v);
      #10;
      check("sweep_ZN", {15'd0, ZN}, {15'd0, exp_zn(v)});
      if (ZN === 1'b0) zeros++;
    end
    check("sweep_zero_count", 16'(zeros), 16'd27);

    // Hand-computed pins.
    set_in(6'b010101); #1; check("lit_010101", {15'd0, ZN}, 16'd0);
    set_in(6'b111111); #1; check("lit_111111", {15'd0, ZN}, 16'd0);
    set_in(6'b000000); #1; check("lit_000000", {15'd0, ZN}, 16'd1);
    set_in(6'b111100); #1; check("lit_111100", {15'd0, ZN}, 16'd1);
    set_in(6'b101000); #1; check("lit_101000", {15'd0, ZN}, 16'd1);
    set_in(6'b111100); #1; check("maskC_00", {15'd0, ZN}, 16'd1);
    set_in(6'b111101); #1; check("maskC_01", {15'd0, ZN}, 16'd0);
    set_in(6'b111110); #1; check("maskC_10", {15'd0, ZN}, 16'd0);
    set_in(6'b111111); #1; check("maskC_11", {15'd0, ZN}, 16'd0);
    set_in(6'b001111); #1; check("maskA_00", {15'd0, ZN}, 16'd1);
    set_in(6'b011111); #1; check("maskA_01", {15'd0, ZN}, 16'd0);
    set_in(6'b101111); #1; check("maskA_10", {15'd0, ZN}, 16'd0);
    set_in(6'b111111); #1; check("maskA_11", {15'd0, ZN}, 16'd0);
    set_in(6'b100100); #1;
    check("grp_100100", {13'd0, grp_or}, 16'b110);
    check("grp_100100_ZN", {15'd0, ZN}, 16'd1);
    set_in(6'b011001); #1;
    check("grp_011001", {13'd0, grp_or}, 16'b111);
    check("grp_011001_ZN", {15'd0, ZN}, 16'd0);
    check_reset_regs("rst_hold");

    // Release reset away from an edge, then random traffic.
    @(posedge clk); #1;
    rst = 1'b0;
    for (int unsigned i = 0; i < 300; i++) apply(6'($urandom));

    // Mid-run reset pulse between edges.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_regs("pulse");
    @(posedge clk); #1;
    rst = 1'b0;
    apply(6'b111111);
    check("edge1_zn_q",     {15'd0, zn_q},     16'd0);
    check("edge1_seen_low", {15'd0, seen_low}, 16'd1);
    check("edge1_tog_cnt",  tog_cnt,           16'd0);
    apply(6'b000000);
    check("edge2_zn_q",      {15'd0, zn_q},      16'd1);
    check("edge2_seen_high", {15'd0, seen_high}, 16'd1);
    check("edge2_tog_cnt",   tog_cnt,            16'd1);

    // Saturation.
    for (int unsigned i = 0; i < 70000; i++)
      apply(i[0] ? 6'b000000 : 6'b111111);
    check("sat_cnt", tog_cnt, 16'hFFFF);
    for (int unsigned i = 0; i < 8; i++)
      apply(i[0] ? 6'b111111 : 6'b000000);
    check("sat_hold", tog_cnt, 16'hFFFF);

    // Async reset during counting, with ZN tracking inputs during reset.
    for (int unsigned i = 0; i < 20; i++) apply(6'($urandom));
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_regs("async");
    for (int unsigned i = 0; i < 10; i++) begin
      v = 6'($urandom);
      set_in(v);
      #3;
      check("rst_ZN", {15'd0, ZN}, {15'd0, exp_zn(v)});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int unsigned i = 0; i < 50; i++) apply(6'($urandom));

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
